// File: rtl/tetris_step_sequencer.sv
// Game-step controller for the Tetris playfield: gravity tick, move requests,
// lock and line-clear sequencing. Issues one command at a time to the grid
// datapath and waits for its single response before issuing the next.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no game; waiting for start
// S_CLR    | CLEAR the grid
// S_SPAWN  | SPAWN a new piece; collision ends the game
// S_WAIT   | piece in play; waiting for a move request or gravity tick
// S_MOVE   | TEST(dx,0) for a requested sideways move
// S_MCOMMIT| COMMIT(dx,0) after a free sideways move
// S_FALL   | TEST(0,+1) for gravity
// S_FCOMMIT| COMMIT(0,+1) after a free fall
// S_LOCK   | LOCK the piece into the grid
// S_SCAN   | ROWFULL(row), scanning from the bottom row up
// S_SHIFT  | SHIFT(row) to remove a full row
// S_OVER   | game over; waiting for start
module tetris_step_sequencer #(
  parameter int ROWS     = 16,
  parameter int ROW_W    = 4,
  parameter int TICK_DIV = 32768
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ctrl1,
  input  logic             ctrl2,
  output logic             cmd_valid,
  output logic [2:0]       cmd_op,
  output logic [1:0]       cmd_dx,
  output logic             cmd_dy,
  output logic [ROW_W-1:0] cmd_row,
  input  logic             cmd_ready,
  input  logic             rsp_valid,
  input  logic             rsp_hit,
  output logic [15:0]      lines_cleared,
  output logic             piece_locked,
  output logic             game_over,
  output logic             busy
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);

  localparam logic [2:0] OP_CLEAR   = 3'd0;
  localparam logic [2:0] OP_SPAWN   = 3'd1;
  localparam logic [2:0] OP_TEST    = 3'd2;
  localparam logic [2:0] OP_COMMIT  = 3'd3;
  localparam logic [2:0] OP_LOCK    = 3'd4;
  localparam logic [2:0] OP_ROWFULL = 3'd5;
  localparam logic [2:0] OP_SHIFT   = 3'd6;

  localparam logic [1:0] DX_LEFT  = 2'b11;
  localparam logic [1:0] DX_RIGHT = 2'b01;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_SPAWN, S_WAIT, S_MOVE, S_MCOMMIT,
    S_FALL, S_FCOMMIT, S_LOCK, S_SCAN, S_SHIFT, S_OVER
  } state_t;

  state_t             state_q, state_d;
  logic               outstanding_q, outstanding_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic               tick_pending_q, tick_pending_d;
  logic               move_pending_q, move_pending_d;
  logic [1:0]         move_dx_q, move_dx_d;
  logic               ctrl1_q, ctrl2_q;
  logic               cmd_valid_d, cmd_dy_d, locked_d;
  logic [2:0]         cmd_op_d;
  logic [1:0]         cmd_dx_d;
  logic [ROW_W-1:0]   cmd_row_d;
  logic [15:0]        lines_d;

  logic               issue, clr_tick, clr_move;
  logic [2:0]         issue_op;
  logic [1:0]         issue_dx;
  logic               issue_dy;
  logic [ROW_W-1:0]   issue_row;

  logic running, can_issue, rsp_done, tick_wrap, rise1, rise2;

  // The tick and the buttons only matter while a game is in progress.
  assign running   = (state_q != S_IDLE) && (state_q != S_OVER);
  assign can_issue = !cmd_valid && !outstanding_q;
  assign rsp_done  = outstanding_q && rsp_valid;
  assign tick_wrap = running && (tick_cnt_q == TICK_LAST);
  assign rise1     = ctrl1 && !ctrl1_q;
  assign rise2     = ctrl2 && !ctrl2_q;

  assign game_over = (state_q == S_OVER);
  assign busy      = !(state_q inside {S_IDLE, S_WAIT, S_OVER});

  // State, command and bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cmd_valid      <= 1'b0;
      cmd_op         <= 3'd0;
      cmd_dx         <= 2'd0;
      cmd_dy         <= 1'b0;
      cmd_row        <= '0;
      outstanding_q  <= 1'b0;
      row_q          <= '0;
      lines_cleared  <= 16'd0;
      piece_locked   <= 1'b0;
      tick_cnt_q     <= '0;
      tick_pending_q <= 1'b0;
      move_pending_q <= 1'b0;
      move_dx_q      <= 2'd0;
      ctrl1_q        <= 1'b0;
      ctrl2_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_valid      <= cmd_valid_d;
      cmd_op         <= cmd_op_d;
      cmd_dx         <= cmd_dx_d;
      cmd_dy         <= cmd_dy_d;
      cmd_row        <= cmd_row_d;
      outstanding_q  <= outstanding_d;
      row_q          <= row_d;
      lines_cleared  <= lines_d;
      piece_locked   <= locked_d;
      tick_cnt_q     <= tick_cnt_d;
      tick_pending_q <= tick_pending_d;
      move_pending_q <= move_pending_d;
      move_dx_q      <= move_dx_d;
      ctrl1_q        <= ctrl1;
      ctrl2_q        <= ctrl2;
    end
  end

  // Next-state, command issue, handshake, tick and move-capture logic.
  always_comb begin
    state_d        = state_q;
    cmd_valid_d    = cmd_valid;
    cmd_op_d       = cmd_op;
    cmd_dx_d       = cmd_dx;
    cmd_dy_d       = cmd_dy;
    cmd_row_d      = cmd_row;
    outstanding_d  = outstanding_q;
    row_d          = row_q;
    lines_d        = lines_cleared;
    locked_d       = 1'b0;
    tick_cnt_d     = tick_cnt_q;
    tick_pending_d = tick_pending_q;
    move_pending_d = move_pending_q;
    move_dx_d      = move_dx_q;
    issue          = 1'b0;
    issue_op       = OP_CLEAR;
    issue_dx       = 2'd0;
    issue_dy       = 1'b0;
    issue_row      = '0;
    clr_tick       = 1'b0;
    clr_move       = 1'b0;

    if (cmd_valid && cmd_ready) begin
      cmd_valid_d   = 1'b0;
      outstanding_d = 1'b1;
    end
    if (rsp_done) outstanding_d = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d = S_CLR;
          lines_d = 16'd0;
        end
      end
      S_CLR: begin
        if (can_issue) begin
          issue    = 1'b1;
          issue_op = OP_CLEAR;
        end
        if (rsp_done) state_d = S_SPAWN;
      end
      S_SPAWN: begin
        if (can_issue) begin
          issue    = 1'b1;
          issue_op = OP_SPAWN;
        end
        if (rsp_done) state_d = rsp_hit ? S_OVER : S_WAIT;
      end
      S_WAIT: begin
        if (move_pending_q)      state_d = S_MOVE;
        else if (tick_pending_q) state_d = S_FALL;
      end
      S_MOVE: begin
        if (can_issue) begin
          issue    = 1'b1;
          issue_op = OP_TEST;
          issue_dx = move_dx_q;
          clr_move = 1'b1;
        end
        if (rsp_done) state_d = rsp_hit ? S_WAIT : S_MCOMMIT;
      end
      S_MCOMMIT: begin
        // cmd_dx still holds the offset that was just tested; move_dx_q may
        // already carry a newer request.
        if (can_issue) begin
          issue    = 1'b1;
          issue_op = OP_COMMIT;
          issue_dx = cmd_dx;
        end
        if (rsp_done) state_d = S_WAIT;
      end
      S_FALL: begin
        if (can_issue) begin
          issue    = 1'b1;
          issue_op = OP_TEST;
          issue_dy = 1'b1;
          clr_tick = 1'b1;
        end
        if (rsp_done) state_d = rsp_hit ? S_LOCK : S_FCOMMIT;
      end
      S_FCOMMIT: begin
        if (can_issue) begin
          issue    = 1'b1;
          issue_op = OP_COMMIT;
          issue_dy = 1'b1;
        end
        if (rsp_done) state_d = S_WAIT;
      end
      S_LOCK: begin
        if (can_issue) begin
          issue    = 1'b1;
          issue_op = OP_LOCK;
        end
        if (rsp_done) begin
          locked_d = 1'b1;
          row_d    = ROW_LAST;
          state_d  = S_SCAN;
        end
      end
      S_SCAN: begin
        if (can_issue) begin
          issue     = 1'b1;
          issue_op  = OP_ROWFULL;
          issue_row = row_q;
        end
        if (rsp_done) begin
          if (rsp_hit) begin
            if (lines_cleared != 16'hFFFF) lines_d = lines_cleared + 16'd1;
            state_d = S_SHIFT;
          end else if (row_q != '0) begin
            row_d = row_q - 1'b1;
          end else begin
            state_d = S_SPAWN;
          end
        end
      end
      S_SHIFT: begin
        // Rows above drop into this row, so it is scanned again.
        if (can_issue) begin
          issue     = 1'b1;
          issue_op  = OP_SHIFT;
          issue_row = row_q;
        end
        if (rsp_done) state_d = S_SCAN;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      cmd_valid_d = 1'b1;
      cmd_op_d    = issue_op;
      cmd_dx_d    = issue_dx;
      cmd_dy_d    = issue_dy;
      cmd_row_d   = issue_row;
    end

    if (running) tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + 1'b1;
    if (clr_tick)  tick_pending_d = 1'b0;
    if (tick_wrap) tick_pending_d = 1'b1;

    // Buttons are ignored outside a game so a stale press cannot act on restart.
    if (clr_move) move_pending_d = 1'b0;
    if (running) begin
      if (rise1 && !ctrl2) begin
        move_pending_d = 1'b1;
        move_dx_d      = DX_LEFT;
      end else if (rise2 && !ctrl1) begin
        move_pending_d = 1'b1;
        move_dx_d      = DX_RIGHT;
      end
    end
  end

endmodule

// File: tb/tb_tetris_step_sequencer.sv
// Directed bench for tetris_step_sequencer with a small grid-datapath responder.
module tb_tetris_step_sequencer;

  localparam int ROWS     = 16;
  localparam int ROW_W    = 4;
  localparam int TICK_DIV = 8;

  localparam logic [2:0] OP_CLEAR   = 3'd0;
  localparam logic [2:0] OP_SPAWN   = 3'd1;
  localparam logic [2:0] OP_TEST    = 3'd2;
  localparam logic [2:0] OP_COMMIT  = 3'd3;
  localparam logic [2:0] OP_LOCK    = 3'd4;
  localparam logic [2:0] OP_ROWFULL = 3'd5;
  localparam logic [2:0] OP_SHIFT   = 3'd6;

  logic clk = 1'b0;
  logic reset, start, ctrl1, ctrl2, cmd_ready, rsp_valid, rsp_hit;
  logic cmd_valid, cmd_dy, piece_locked, game_over, busy;
  logic [2:0] cmd_op;
  logic [1:0] cmd_dx;
  logic [ROW_W-1:0] cmd_row;
  logic [15:0] lines_cleared;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int locked_pulses = 0;
  logic [9:0] log_cmd[$];
  int log_cyc[$];
  logic fall_hit = 1'b0, spawn_hit = 1'b0, hold_shift = 1'b0, stray_req = 1'b0;
  logic [15:0] full_rows = 16'h0000;

  tetris_step_sequencer #(.ROWS(ROWS), .ROW_W(ROW_W), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .ctrl1(ctrl1), .ctrl2(ctrl2),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_dx(cmd_dx), .cmd_dy(cmd_dy),
    .cmd_row(cmd_row), .cmd_ready(cmd_ready), .rsp_valid(rsp_valid),
    .rsp_hit(rsp_hit), .lines_cleared(lines_cleared), .piece_locked(piece_locked),
    .game_over(game_over), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle stamp for the command log.
  always @(posedge clk) cyc <= cyc + 1;

  // Count cycles with piece_locked high.
  initial forever begin
    @(posedge clk); #1;
    if (piece_locked) locked_pulses++;
  end

  // Grid datapath stand-in: logs accepted commands and answers one cycle later.
  initial begin : responder
    logic pend, pend_hit;
    pend = 1'b0;
    pend_hit = 1'b0;
    rsp_valid = 1'b0;
    rsp_hit = 1'b0;
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_hit = 1'b0;
      if (stray_req) begin
        rsp_valid = 1'b1;
        rsp_hit = 1'b1;
        stray_req = 1'b0;
      end else if (pend) begin
        rsp_valid = 1'b1;
        rsp_hit = pend_hit;
        pend = 1'b0;
      end
      if (reset && cmd_valid && cmd_ready) begin
        log_cmd.push_back({cmd_op, cmd_dx, cmd_dy, cmd_row});
        log_cyc.push_back(cyc);
        pend_hit = 1'b0;
        case (cmd_op)
          OP_SPAWN:   pend_hit = spawn_hit;
          OP_TEST:    pend_hit = cmd_dy & fall_hit;
          OP_ROWFULL: pend_hit = full_rows[cmd_row];
          OP_SHIFT: begin
            for (int i = ROWS - 1; i > 0; i--)
              if (i <= int'(cmd_row)) full_rows[i] = full_rows[i-1];
            full_rows[0] = 1'b0;
          end
          default: ;
        endcase
        pend = !(hold_shift && cmd_op == OP_SHIFT);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, n_bad=%0d", n_bad);
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [9:0] mk(input logic [2:0] op, input logic [1:0] dx,
                                    input logic dy, input logic [3:0] row);
    return {op, dx, dy, row};
  endfunction

  task automatic wait_log(input int n, input int budget, input string tag);
    int k = 0;
    while (log_cmd.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check_val(tag, 32'(log_cmd.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((busy || cmd_valid) && k < 100) begin
      tick(1);
      k++;
    end
    check_val(tag, 32'(!busy), 32'd1);
  endtask

  task automatic check_cmd(input string tag, input int idx, input logic [9:0] exp);
    logic [9:0] got;
    got = (idx < log_cmd.size()) ? log_cmd[idx] : 10'h3FF;
    check_val(tag, 32'(got), 32'(exp));
  endtask

  logic [9:0] exp_seq[$];
  logic [9:0] snap;
  int n0, n1, n2, n3, n4, cnt_dx, cnt_fall;

  initial begin
    reset = 1'b0; start = 1'b0; ctrl1 = 1'b0; ctrl2 = 1'b0; cmd_ready = 1'b1;
    tick(3);
    check_val("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check_val("rst_fields", 32'({cmd_op, cmd_dx, cmd_dy, cmd_row}), 32'd0);
    check_val("rst_lines", 32'(lines_cleared), 32'd0);
    check_val("rst_flags", 32'({piece_locked, game_over, busy}), 32'd0);
    reset = 1'b1;
    tick(4);
    check_val("idle_no_cmd", 32'(log_cmd.size()), 32'd0);

    // 1: start, CLEAR, SPAWN, then a fall every TICK_DIV cycles
    start = 1'b1; tick(1); start = 1'b0;
    check_val("start_busy", 32'(busy), 32'd1);
    wait_log(6, 100, "t1_timeout");
    check_cmd("t1_clear",   0, mk(OP_CLEAR, 2'b00, 1'b0, 4'd0));
    check_cmd("t1_spawn",   1, mk(OP_SPAWN, 2'b00, 1'b0, 4'd0));
    check_cmd("t1_test0",   2, mk(OP_TEST, 2'b00, 1'b1, 4'd0));
    check_cmd("t1_commit0", 3, mk(OP_COMMIT, 2'b00, 1'b1, 4'd0));
    check_cmd("t1_test1",   4, mk(OP_TEST, 2'b00, 1'b1, 4'd0));
    check_cmd("t1_commit1", 5, mk(OP_COMMIT, 2'b00, 1'b1, 4'd0));
    check_val("t1_period", 32'(log_cyc[4] - log_cyc[2]), 32'(TICK_DIV));
    check_val("t1_lines", 32'(lines_cleared), 32'd0);
    tick(1);
    check_val("t1_wait_busy", 32'({busy, cmd_valid}), 32'd0);

    // 4 + 2: stall the next FALL TEST, tap ctrl1 and let a tick pile up meanwhile
    cmd_ready = 1'b0;
    n0 = log_cmd.size();
    begin
      int k = 0;
      while (!cmd_valid && k < 30) begin tick(1); k++; end
    end
    check_val("t4_valid_seen", 32'(cmd_valid), 32'd1);
    snap = {cmd_op, cmd_dx, cmd_dy, cmd_row};
    check_val("t4_fields", 32'(snap), 32'(mk(OP_TEST, 2'b00, 1'b1, 4'd0)));
    ctrl1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      ctrl1 = 1'b0;
      check_val("t4_hold_valid", 32'(cmd_valid), 32'd1);
      check_val("t4_hold_fields", 32'({cmd_op, cmd_dx, cmd_dy, cmd_row}), 32'(snap));
    end
    tick(6);
    check_val("t4_none_accepted", 32'(log_cmd.size()), 32'(n0));
    cmd_ready = 1'b1;
    tick(2);
    check_val("t4_one_accepted", 32'(log_cmd.size()), 32'(n0 + 1));
    wait_log(n0 + 5, 100, "t2_timeout");
    check_cmd("t2_fall_test",    n0,     mk(OP_TEST, 2'b00, 1'b1, 4'd0));
    check_cmd("t2_fall_commit",  n0 + 1, mk(OP_COMMIT, 2'b00, 1'b1, 4'd0));
    check_cmd("t2_move_test",    n0 + 2, mk(OP_TEST, 2'b11, 1'b0, 4'd0));
    check_cmd("t2_move_commit",  n0 + 3, mk(OP_COMMIT, 2'b11, 1'b0, 4'd0));
    check_cmd("t2_pending_fall", n0 + 4, mk(OP_TEST, 2'b00, 1'b1, 4'd0));

    // 2: both buttons together never produce a sideways TEST
    ctrl1 = 1'b1; ctrl2 = 1'b1;
    n1 = log_cmd.size();
    tick(40);
    ctrl1 = 1'b0; ctrl2 = 1'b0;
    tick(2);
    cnt_dx = 0; cnt_fall = 0;
    for (int i = n1; i < log_cmd.size(); i++) begin
      if (log_cmd[i][9:7] == OP_TEST && log_cmd[i][6:5] != 2'b00) cnt_dx++;
      if (log_cmd[i] == mk(OP_TEST, 2'b00, 1'b1, 4'd0)) cnt_fall++;
    end
    check_val("t2_both_no_move", 32'(cnt_dx), 32'd0);
    check_val("t2_both_falls", 32'(cnt_fall >= 4), 32'd1);

    // 3: fall blocked -> LOCK, rows 15 and 14 full -> two clears, then SPAWN
    wait_idle("t3_idle");
    full_rows = 16'hC000;
    fall_hit = 1'b1;
    locked_pulses = 0;
    n2 = log_cmd.size();
    exp_seq = {};
    exp_seq.push_back(mk(OP_TEST, 2'b00, 1'b1, 4'd0));
    exp_seq.push_back(mk(OP_LOCK, 2'b00, 1'b0, 4'd0));
    exp_seq.push_back(mk(OP_ROWFULL, 2'b00, 1'b0, 4'd15));
    exp_seq.push_back(mk(OP_SHIFT, 2'b00, 1'b0, 4'd15));
    exp_seq.push_back(mk(OP_ROWFULL, 2'b00, 1'b0, 4'd15));
    exp_seq.push_back(mk(OP_SHIFT, 2'b00, 1'b0, 4'd15));
    for (int r = 15; r >= 0; r--) exp_seq.push_back(mk(OP_ROWFULL, 2'b00, 1'b0, 4'(r)));
    exp_seq.push_back(mk(OP_SPAWN, 2'b00, 1'b0, 4'd0));
    wait_log(n2 + 2, 100, "t3_lock_timeout");
    fall_hit = 1'b0;
    wait_log(n2 + exp_seq.size(), 300, "t3_timeout");
    for (int i = 0; i < exp_seq.size(); i++) check_cmd("t3_seq", n2 + i, exp_seq[i]);
    check_val("t3_lines", 32'(lines_cleared), 32'd2);
    check_val("t3_locked_pulses", 32'(locked_pulses), 32'd1);

    // 5: blocked SPAWN -> OVER; start restarts cleanly
    wait_idle("t5_idle");
    full_rows = 16'h0000;
    fall_hit = 1'b1;
    spawn_hit = 1'b1;
    n3 = log_cmd.size();
    wait_log(n3 + 19, 300, "t5_timeout");
    check_cmd("t5_last_rowfull", n3 + 17, mk(OP_ROWFULL, 2'b00, 1'b0, 4'd0));
    check_cmd("t5_spawn", n3 + 18, mk(OP_SPAWN, 2'b00, 1'b0, 4'd0));
    fall_hit = 1'b0;
    spawn_hit = 1'b0;
    tick(3);
    check_val("t5_over_flags", 32'({game_over, busy, cmd_valid}), 32'b100);
    ctrl1 = 1'b1; tick(1); ctrl1 = 1'b0;
    tick(20);
    check_val("t5_over_no_cmd", 32'(log_cmd.size()), 32'(n3 + 19));
    check_val("t5_over_lines", 32'(lines_cleared), 32'd2);
    start = 1'b1; tick(1); start = 1'b0;
    check_val("t5_restart_lines", 32'(lines_cleared), 32'd0);
    check_val("t5_restart_flags", 32'({game_over, busy}), 32'b01);
    wait_log(n3 + 23, 100, "t5_restart_timeout");
    check_cmd("t5_clear", n3 + 19, mk(OP_CLEAR, 2'b00, 1'b0, 4'd0));
    check_cmd("t5_spawn2", n3 + 20, mk(OP_SPAWN, 2'b00, 1'b0, 4'd0));
    check_cmd("t5_no_stale_move", n3 + 21, mk(OP_TEST, 2'b00, 1'b1, 4'd0));

    // 6: reset while a SHIFT is outstanding, then a stray response
    wait_idle("t6_idle");
    full_rows = 16'h8000;
    fall_hit = 1'b1;
    hold_shift = 1'b1;
    n4 = log_cmd.size();
    wait_log(n4 + 4, 100, "t6_timeout");
    fall_hit = 1'b0;
    check_cmd("t6_shift", n4 + 3, mk(OP_SHIFT, 2'b00, 1'b0, 4'd15));
    check_val("t6_pre_lines", 32'(lines_cleared), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_val("t6_rst_valid", 32'(cmd_valid), 32'd0);
    check_val("t6_rst_fields", 32'({cmd_op, cmd_dx, cmd_dy, cmd_row}), 32'd0);
    check_val("t6_rst_lines", 32'(lines_cleared), 32'd0);
    check_val("t6_rst_flags", 32'({piece_locked, game_over, busy}), 32'd0);
    tick(1);
    reset = 1'b1;
    hold_shift = 1'b0;
    tick(1);
    stray_req = 1'b1;
    tick(6);
    check_val("t6_stray_idle", 32'({busy, game_over, cmd_valid}), 32'd0);
    check_val("t6_stray_no_cmd", 32'(log_cmd.size()), 32'(n4 + 4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tetris_step_sequencer.md
Name: tetris_step_sequencer

Overview:
- Game-step controller for the Tetris playfield datapath. It owns the gravity tick, player move requests, lock and line-clear sequencing.
- It issues single-outstanding commands to the grid datapath (spawn, test/commit move, lock, row-full query, row shift, clear) and consumes one response per command.
- The grid datapath holds all cell state; this block holds only control state, the tick counter and the score.

Parameters:
ROWS, 16, playfield rows; scan runs from ROWS-1 down to 0.
ROW_W, 4, width of cmd_row; must satisfy 2^ROW_W >= ROWS.
TICK_DIV, 32768, clk cycles per gravity tick; minimum 2.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; starts a new game from IDLE or OVER.
ctrl1  in  1  move-left button, synchronous level.
ctrl2  in  1  move-right button, synchronous level.
cmd_valid  out  1  command valid.
cmd_op  out  3  0=CLEAR, 1=SPAWN, 2=TEST, 3=COMMIT, 4=LOCK, 5=ROWFULL, 6=SHIFT.
cmd_dx  out  2  signed x offset for TEST/COMMIT (-1, 0, +1).
cmd_dy  out  1  y offset for TEST/COMMIT (0 or +1).
cmd_row  out  ROW_W  row for ROWFULL/SHIFT.
cmd_ready  in  1  datapath accepts the command this cycle.
rsp_valid  in  1  one-cycle response pulse.
rsp_hit  in  1  SPAWN/TEST: collision; ROWFULL: row full; other ops: ignored.
lines_cleared  out  16  count of rows cleared this game; saturates at 16'hFFFF.
piece_locked  out  1  one-cycle pulse on LOCK response.
game_over  out  1  high in OVER.
busy  out  1  high in every state except IDLE, WAIT and OVER.

Behaviour:
- Reset (async assert, sync deassert effect):
  - State = IDLE.
  - cmd_valid = 0; cmd_op, cmd_dx, cmd_dy, cmd_row = 0.
  - lines_cleared = 0; piece_locked, game_over, busy = 0.
  - Tick counter = 0; tick_pending = 0; move_pending = 0.
  - Reset mid-command drops the command immediately; the datapath is not notified.
- Command handshake:
  - cmd_valid rises with all fields; fields are held stable until the cycle cmd_valid and cmd_ready are both high.
  - cmd_valid drops the cycle after acceptance.
  - Only one command is outstanding at a time. The next command is issued no earlier than the cycle after rsp_valid.
  - rsp_valid with no outstanding command is ignored.
- Tick counter:
  - Free-runs in every state except IDLE and OVER; wraps at TICK_DIV-1.
  - Wrap sets the sticky tick_pending flag. Several wraps while busy collapse into one pending tick.
  - tick_pending clears when the FALL TEST is issued.
- Move capture:
  - A rising edge of ctrl1 with ctrl2 low latches move_pending with dx = -1.
  - A rising edge of ctrl2 with ctrl1 low latches move_pending with dx = +1.
  - Both buttons high: no capture. A new edge overwrites a pending move.
- States:
  - IDLE: on start, go to CLR.
  - CLR: issue CLEAR; lines_cleared <= 0; on response, go to SPAWN.
  - SPAWN: issue SPAWN. hit -> OVER; else -> WAIT.
  - WAIT: if move_pending -> MOVE (move has priority when a tick is pending in the same cycle); else if tick_pending -> FALL.
  - MOVE: issue TEST(dx, 0) and clear move_pending. No hit -> COMMIT(dx, 0). Then return to WAIT; a blocked move is discarded.
  - FALL: issue TEST(0, +1). No hit -> COMMIT(0, +1), then WAIT. Hit -> LOCK.
  - LOCK: issue LOCK; piece_locked pulses with the response; row = ROWS-1; go to SCAN.
  - SCAN: issue ROWFULL(row).
    - hit -> SHIFT(row), which moves rows row-1..0 down one and blanks row 0. lines_cleared++ (saturating). Rescan the same row.
    - Miss with row > 0 -> row--, SCAN.
    - Miss with row == 0 -> SPAWN.
  - OVER: game_over = 1; ctrl inputs ignored; on start, go to CLR.
- start outside IDLE/OVER is ignored.
- Worst-case lock cost: ROWS ROWFULL commands plus 2 commands per cleared row.

Test Plan:
1. TICK_DIV=8, ready and response tied to 1-cycle latency, no hits: reset, start -> CLEAR then SPAWN; thereafter TEST(0,+1)+COMMIT every 8 cycles; lines_cleared=0; busy low in WAIT.
2. Tap ctrl1 mid-WAIT with a tick also pending -> TEST(-1,0), COMMIT(-1,0), then TEST(0,+1). Hold both buttons -> no TEST with dx != 0.
3. FALL TEST returns hit -> LOCK with one piece_locked pulse. Then ROWFULL rows 15..0; with rsp_hit on rows 15 and 14 -> SHIFT 15, rescan 15, SHIFT 15 again, then 14..0; lines_cleared=2; then SPAWN.
4. cmd_ready held low 5 cycles -> cmd_valid and fields stable for all 5 cycles; exactly one command accepted.
5. SPAWN returns hit -> game_over=1, no further commands. start -> CLEAR, lines_cleared=0, game_over=0.
6. Assert reset while a SHIFT is outstanding -> cmd_valid=0 and all outputs at reset values in the same cycle. A stray rsp_valid afterwards is ignored; state stays IDLE.
